// File: rtl/image_frame_loader.sv
// Collects 28 seven-bit chunks from an asynchronous microcontroller strobe into a
// 14x14 binary frame and offers the finished frame to the classifier over valid/ready.
module image_frame_loader (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [6:0]   data_in,
   input  logic         strobe_in,
   input  logic         frame_abort,
   input  logic         frame_ready,
   output logic [195:0] frame_out,
   output logic         frame_valid,
   output logic         busy,
   output logic         overrun,
   output logic [4:0]   chunk_count
);

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      FULL
   } state_t;

   localparam logic [4:0] LAST_CHUNK = 5'd27;

   state_t     state;
   logic       s1, s2, s3;
   logic       chunk_pulse;
   logic [7:0] chunk_base;

   // s1 is the metastability catcher; the edge is taken between s2 and s3.
   assign chunk_pulse = s2 & ~s3;
   assign chunk_base  = 8'(chunk_count) * 8'd7;

   // NOTE: every register here uses <= so all flops see pre-edge values, which is
   // what makes a strobe pulse and a handshake at the same edge both judge the old state.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1          <= 1'b0;
         s2          <= 1'b0;
         s3          <= 1'b0;
         state       <= IDLE;
         frame_out   <= '0;
         frame_valid <= 1'b0;
         busy        <= 1'b0;
         overrun     <= 1'b0;
         chunk_count <= '0;
      end else begin
         s1 <= strobe_in;
         s2 <= s1;
         s3 <= s2;

         if (frame_abort) begin
            // The strobe from the same edge is dropped; frame_out and overrun are kept.
            state       <= IDLE;
            chunk_count <= '0;
            frame_valid <= 1'b0;
            busy        <= 1'b0;
         end else begin
            case (state)
               IDLE, LOAD: begin
                  if (chunk_pulse) begin
                     frame_out[chunk_base +: 7] <= data_in;
                     chunk_count                <= chunk_count + 5'd1;
                     if (chunk_count == LAST_CHUNK) begin
                        state       <= FULL;
                        frame_valid <= 1'b1;
                        busy        <= 1'b0;
                     end else begin
                        state <= LOAD;
                        busy  <= 1'b1;
                     end
                  end
               end
               FULL: begin
                  if (chunk_pulse) begin
                     overrun <= 1'b1;
                  end
                  if (frame_ready) begin
                     state       <= IDLE;
                     chunk_count <= '0;
                     frame_valid <= 1'b0;
                  end
               end
               default: begin
                  state       <= IDLE;
                  chunk_count <= '0;
                  frame_valid <= 1'b0;
                  busy        <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: doc/image_frame_loader.md
# image_frame_loader

Upstream input stage of the MNIST accelerator. It receives a 14x14 binary digit image from an external microcontroller as 28 seven-bit chunks on the dedicated inputs. It assembles the chunks into a 196-bit frame buffer and hands the complete frame to the classifier core over a valid/ready handshake. The strobe from the microcontroller is asynchronous, so it is synchronized and edge-detected inside this block.

## Interface
Parameters:
- none (frame geometry is fixed: 14x14 pixels, 7-bit chunks, 28 chunks per frame)

Ports:
- clk  in  1  system clock; the block has one clock. Reset is synchronous and active-low.
- rst_n  in  1  synchronous active-low reset.
- data_in  in  7  pixel chunk, driven from ui_in[6:0].
- strobe_in  in  1  asynchronous chunk strobe, driven from ui_in[7]. Each rising edge delivers one chunk.
- frame_abort  in  1  synchronous pulse. Discards the partial or held frame.
- frame_ready  in  1  classifier can accept the frame.
- frame_out  out  196  assembled image. Pixel (row r, column c) is at bit 14r+c.
- frame_valid  out  1  frame_out holds a complete frame.
- busy  out  1  partial frame in progress (1 to 27 chunks stored).
- overrun  out  1  sticky. A chunk arrived while the buffer was full.
- chunk_count  out  5  chunks stored so far, 0 to 28.

## Operation
- Strobe path:
  - s1 <= strobe_in; s2 <= s1; s3 <= s2.
  - Chunk pulse p = s2 & ~s3.
  - All three flops reset to 0. If strobe_in is held high across reset release, that counts as a rising edge, so the microcontroller must hold strobe_in low during reset.
- Chunk placement: chunk k (k = 0 to 27) is written to frame_out[7k+6:7k], with data_in[0] going to bit 7k.
  - Chunk 2r holds columns 0-6 of row r; chunk 2r+1 holds columns 7-13.
- States:
  - IDLE (count 0).
  - LOAD (count 1 to 27).
  - FULL (count 28, frame_valid=1).
- Transitions on p:
  - IDLE to LOAD.
  - LOAD to LOAD, or LOAD to FULL when the 28th chunk is written.
- In FULL, p drops the chunk, sets overrun, and leaves frame_out unchanged.
- Handshake: frame_valid & frame_ready at a clock edge transfers the frame. Next cycle: IDLE, count 0, frame_valid 0.
  - frame_out is not cleared after a transfer. Its bits are overwritten chunk by chunk as the next frame loads.
- frame_valid is asserted only in FULL. frame_out is stable while frame_valid=1.
- frame_abort forces IDLE and count 0, and deasserts frame_valid. It does not clear frame_out or overrun.
- Priority at a single edge:
  1. rst_n=0
  2. frame_abort
  3. handshake / p
- Simultaneous events:
  - p and frame_abort: abort wins and the chunk is dropped. overrun is not set.
  - p and handshake in FULL: p is judged against the pre-edge state FULL, so the chunk is dropped and overrun is set. The transfer still completes.
  - frame_abort and frame_ready in FULL: no transfer. The frame is discarded.
- overrun clears only on reset.
- busy = (state == LOAD).

## Timing
- All outputs are registered. Reset values:
  - frame_out = 0, frame_valid = 0, busy = 0, overrun = 0, chunk_count = 0.
  - s1, s2, s3 = 0, state = IDLE.
- Capture latency: strobe_in is first sampled high at edge E0. p is high between E1 and E2. data_in is captured at E2, and chunk_count increments at E2.
- Microcontroller timing requirements:
  - data_in stable from the strobe_in rise through E2, i.e. at least 3 clk cycles.
  - strobe_in high for at least 3 cycles, then low for at least 3 cycles.
  - Minimum chunk period is 6 cycles.
- If the 28th chunk is captured at edge E, frame_valid=1 and chunk_count=28 immediately after E.
- Handshake completing at edge H: frame_valid=0 and chunk_count=0 after H. The next frame's first chunk can be captured at H+1 or later.
- Reset mid-frame: the partial frame is lost, and every output returns to its reset value after the reset edge.

## Test plan
- Full load: send 28 chunks, chunk k = k[6:0], with frame_ready=1.
  - frame_out[7k+6:7k] must equal k for every k.
  - frame_valid is high exactly 1 cycle.
  - chunk_count returns to 0.
- Held frame: load 28 chunks of 7'h55 with frame_ready=0 for 20 cycles.
  - frame_valid stays 1 and frame_out is unchanged throughout.
  - Raising frame_ready gives a 1-cycle transfer.
- Overrun: in FULL with frame_ready=0, send one chunk of 7'h7F.
  - overrun=1 and frame_out is unchanged.
  - overrun stays 1 after a later transfer and a subsequent full frame.
- Abort: send 10 chunks, then pulse frame_abort.
  - chunk_count=0, busy=0, overrun=0.
  - A following 28-chunk frame loads correctly.
  - Repeat with p and frame_abort at the same edge: the count is unchanged at 0.
- Reset mid-frame: send 15 chunks, then drive rst_n=0 for 1 cycle.
  - All outputs take their reset values.
  - Repeat with strobe_in held high through reset release: exactly one chunk is captured 2 cycles after release.
- Back-to-back frames at the minimum 6-cycle chunk period with frame_ready tied to 1: two consecutive frames arrive intact with no overrun.
